// File: rtl/ram_ctrl_pkg.sv
// Shared types for the RAM request scheduler: size codes, FSM states and
// the latched request record.
package ram_ctrl_pkg;

  localparam int unsigned REQ_ADDR_W = 32;
  localparam int unsigned REQ_DATA_W = 32;

  // Access size encodings carried on pN_req_size.
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // One accepted request, held from the accept edge until the response.
  typedef struct packed {
    logic                  we;
    logic [1:0]            size;
    logic                  sgn;
    logic [REQ_ADDR_W-1:0] addr;
    logic [REQ_DATA_W-1:0] wdata;
  } req_t;

  // True when the access would run past the end of the RAM or uses the
  // reserved size code.
  function automatic logic req_is_bad(input logic [REQ_ADDR_W-1:0] addr,
                                      input logic [1:0] size,
                                      input logic [REQ_ADDR_W-1:0] max_addr);
    logic bad;
    bad = (addr > max_addr) || (size == SZ_RSVD);
    return bad;
  endfunction

endpackage

// File: rtl/ram_ctrl_lane.sv
// Byte-lane steering between the big-endian RAM word and right-aligned
// request/response data. Purely combinational.
module ram_ctrl_lane
  import ram_ctrl_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_ram_rdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_merge_data
);

  // Extract the addressed bytes for loads and merge store data into the
  // current word; the addressed byte always sits in bits [31:24].
  always_comb begin
    o_load_data  = 32'd0;
    o_merge_data = i_ram_rdata;
    case (i_size)
      SZ_BYTE: begin
        if (i_signed) begin
          o_load_data = {{24{i_ram_rdata[31]}}, i_ram_rdata[31:24]};
        end else begin
          o_load_data = {24'd0, i_ram_rdata[31:24]};
        end
        o_merge_data = {i_wdata[7:0], i_ram_rdata[23:0]};
      end
      SZ_HALF: begin
        if (i_signed) begin
          o_load_data = {{16{i_ram_rdata[31]}}, i_ram_rdata[31:16]};
        end else begin
          o_load_data = {16'd0, i_ram_rdata[31:16]};
        end
        o_merge_data = {i_wdata[15:0], i_ram_rdata[15:0]};
      end
      SZ_WORD: begin
        o_load_data  = i_ram_rdata;
        o_merge_data = i_wdata;
      end
      default: begin
        o_load_data  = 32'd0;
        o_merge_data = i_ram_rdata;
      end
    endcase
  end

endmodule

// File: rtl/ram_ctrl.sv
// Two-port round-robin scheduler in front of the data RAM. One request is
// in flight at a time: IDLE (accept) -> ACCESS (read/merge/write) -> RESP.
module ram_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_BYTES  = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p0_req_valid,
  output logic                  p0_req_ready,
  input  logic                  p0_req_we,
  input  logic [1:0]            p0_req_size,
  input  logic                  p0_req_signed,
  input  logic [ADDR_WIDTH-1:0] p0_req_addr,
  input  logic [DATA_WIDTH-1:0] p0_req_wdata,
  output logic                  p0_resp_valid,
  output logic [DATA_WIDTH-1:0] p0_resp_rdata,
  output logic                  p0_resp_err,
  input  logic                  p1_req_valid,
  output logic                  p1_req_ready,
  input  logic                  p1_req_we,
  input  logic [1:0]            p1_req_size,
  input  logic                  p1_req_signed,
  input  logic [ADDR_WIDTH-1:0] p1_req_addr,
  input  logic [DATA_WIDTH-1:0] p1_req_wdata,
  output logic                  p1_resp_valid,
  output logic [DATA_WIDTH-1:0] p1_resp_rdata,
  output logic                  p1_resp_err,
  output logic [ADDR_WIDTH-1:0] ram_r_addr,
  output logic [ADDR_WIDTH-1:0] ram_w_addr,
  output logic [DATA_WIDTH-1:0] ram_w_data,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_r_data
);

  // Highest legal start address for a 4-byte RAM access.
  localparam logic [ADDR_WIDTH-1:0] LP_MAX_ADDR = ADDR_WIDTH'(MEM_BYTES - 4);

  state_t                r_state;
  state_t                w_next_state;
  req_t                  r_req;
  logic                  r_port;
  logic                  r_last_grant;
  logic                  r_p0_resp_valid;
  logic                  r_p1_resp_valid;
  logic [DATA_WIDTH-1:0] r_p0_resp_rdata;
  logic [DATA_WIDTH-1:0] r_p1_resp_rdata;
  logic                  r_p0_resp_err;
  logic                  r_p1_resp_err;

  logic                  w_any_req;
  logic                  w_win;
  logic                  w_accept;
  logic                  w_err;
  req_t                  w_sel_req;
  logic [DATA_WIDTH-1:0] w_load_data;
  logic [DATA_WIDTH-1:0] w_merge_data;
  logic [DATA_WIDTH-1:0] w_resp_data;

  ram_ctrl_lane u_lane (
    .i_size       (r_req.size),
    .i_signed     (r_req.sgn),
    .i_wdata      (r_req.wdata),
    .i_ram_rdata  (ram_r_data),
    .o_load_data  (w_load_data),
    .o_merge_data (w_merge_data)
  );

  // Round-robin pick: a sole requester wins, a tie goes away from the last grant.
  always_comb begin
    w_any_req = 1'b0;
    w_win     = 1'b0;
    if (p0_req_valid && p1_req_valid) begin
      w_any_req = 1'b1;
      w_win     = ~r_last_grant;
    end else if (p0_req_valid) begin
      w_any_req = 1'b1;
      w_win     = 1'b0;
    end else if (p1_req_valid) begin
      w_any_req = 1'b1;
      w_win     = 1'b1;
    end else begin
      w_any_req = 1'b0;
      w_win     = 1'b0;
    end
  end

  // Mux the winning port's request fields for latching.
  always_comb begin
    w_sel_req = '0;
    if (w_win) begin
      w_sel_req = '{we: p1_req_we, size: p1_req_size, sgn: p1_req_signed,
                    addr: p1_req_addr, wdata: p1_req_wdata};
    end else begin
      w_sel_req = '{we: p0_req_we, size: p0_req_size, sgn: p0_req_signed,
                    addr: p0_req_addr, wdata: p0_req_wdata};
    end
  end

  assign w_accept    = (r_state == ST_IDLE) && w_any_req;
  assign w_err       = req_is_bad(r_req.addr, r_req.size, LP_MAX_ADDR);
  assign w_resp_data = (w_err || r_req.we) ? '0 : w_load_data;

  assign ram_r_addr    = r_req.addr;
  assign ram_w_addr    = r_req.addr;
  assign ram_w_data    = w_merge_data;
  assign p0_resp_valid = r_p0_resp_valid;
  assign p1_resp_valid = r_p1_resp_valid;
  assign p0_resp_rdata = r_p0_resp_rdata;
  assign p1_resp_rdata = r_p1_resp_rdata;
  assign p0_resp_err   = r_p0_resp_err;
  assign p1_resp_err   = r_p1_resp_err;

  // Next-state, ready and write-enable decode; the write is gated by rst so a
  // reset landing in ACCESS never commits.
  always_comb begin
    w_next_state = r_state;
    p0_req_ready = 1'b0;
    p1_req_ready = 1'b0;
    ram_we       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        p0_req_ready = w_any_req & ~w_win;
        p1_req_ready = w_any_req & w_win;
        if (w_any_req) begin
          w_next_state = ST_ACCESS;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        ram_we       = r_req.we & ~w_err & ~rst;
        w_next_state = ST_RESP;
      end
      ST_RESP: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Latch the winning request and remember who was granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req        <= '0;
      r_port       <= 1'b0;
      r_last_grant <= 1'b1;
    end else if (w_accept) begin
      r_req        <= w_sel_req;
      r_port       <= w_win;
      r_last_grant <= w_win;
    end
  end

  // Response registers: loaded at the end of ACCESS for the granted port only;
  // data and error hold between responses, valid is a single-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p0_resp_valid <= 1'b0;
      r_p1_resp_valid <= 1'b0;
      r_p0_resp_rdata <= '0;
      r_p1_resp_rdata <= '0;
      r_p0_resp_err   <= 1'b0;
      r_p1_resp_err   <= 1'b0;
    end else begin
      r_p0_resp_valid <= 1'b0;
      r_p1_resp_valid <= 1'b0;
      if (r_state == ST_ACCESS) begin
        if (r_port) begin
          r_p1_resp_valid <= 1'b1;
          r_p1_resp_rdata <= w_resp_data;
          r_p1_resp_err   <= w_err;
        end else begin
          r_p0_resp_valid <= 1'b1;
          r_p0_resp_rdata <= w_resp_data;
          r_p0_resp_err   <= w_err;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_ctrl.sv
// Directed self-checking bench for ram_ctrl with a behavioural big-endian RAM.
module tb_ram_ctrl;

  localparam logic [1:0] T_BYTE = 2'd0;
  localparam logic [1:0] T_HALF = 2'd1;
  localparam logic [1:0] T_WORD = 2'd2;
  localparam logic [1:0] T_RSVD = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        p0_req_valid = 1'b0, p0_req_ready, p0_req_we = 1'b0, p0_req_signed = 1'b0;
  logic [1:0]  p0_req_size = 2'd0;
  logic [31:0] p0_req_addr = 32'd0, p0_req_wdata = 32'd0, p0_resp_rdata;
  logic        p0_resp_valid, p0_resp_err;
  logic        p1_req_valid = 1'b0, p1_req_ready, p1_req_we = 1'b0, p1_req_signed = 1'b0;
  logic [1:0]  p1_req_size = 2'd0;
  logic [31:0] p1_req_addr = 32'd0, p1_req_wdata = 32'd0, p1_resp_rdata;
  logic        p1_resp_valid, p1_resp_err;
  logic [31:0] ram_r_addr, ram_w_addr, ram_w_data, ram_r_data;
  logic        ram_we;

  int checks = 0;
  int failures = 0;
  int we_count = 0;
  int resp_cnt0 = 0;
  int resp_cnt1 = 0;
  int both_cnt = 0;
  int cyc = 0;
  logic [31:0] last_w_addr = 32'd0;
  logic [31:0] last_w_data = 32'd0;
  logic [7:0]  mem [0:4095];

  ram_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_BYTES(4096)) dut (
    .clk(clk), .rst(rst),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
    .p0_req_size(p0_req_size), .p0_req_signed(p0_req_signed), .p0_req_addr(p0_req_addr),
    .p0_req_wdata(p0_req_wdata), .p0_resp_valid(p0_resp_valid), .p0_resp_rdata(p0_resp_rdata),
    .p0_resp_err(p0_resp_err),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_we(p1_req_we),
    .p1_req_size(p1_req_size), .p1_req_signed(p1_req_signed), .p1_req_addr(p1_req_addr),
    .p1_req_wdata(p1_req_wdata), .p1_resp_valid(p1_resp_valid), .p1_resp_rdata(p1_resp_rdata),
    .p1_resp_err(p1_resp_err),
    .ram_r_addr(ram_r_addr), .ram_w_addr(ram_w_addr), .ram_w_data(ram_w_data),
    .ram_we(ram_we), .ram_r_data(ram_r_data)
  );

  always #5 clk = ~clk;

  // Big-endian combinational read; out-of-range reads return zero.
  assign ram_r_data = (ram_r_addr <= 32'd4092) ?
      {mem[ram_r_addr[11:0]], mem[ram_r_addr[11:0] + 12'd1],
       mem[ram_r_addr[11:0] + 12'd2], mem[ram_r_addr[11:0] + 12'd3]} : 32'd0;

  // RAM write port and write log.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_we) begin
      if (ram_w_addr <= 32'd4092) begin
        mem[ram_w_addr[11:0]]         <= ram_w_data[31:24];
        mem[ram_w_addr[11:0] + 12'd1] <= ram_w_data[23:16];
        mem[ram_w_addr[11:0] + 12'd2] <= ram_w_data[15:8];
        mem[ram_w_addr[11:0] + 12'd3] <= ram_w_data[7:0];
      end
      we_count    <= we_count + 1;
      last_w_addr <= ram_w_addr;
      last_w_data <= ram_w_data;
    end
  end

  // Response pulse counters sampled away from the active edge.
  always @(negedge clk) begin
    if (p0_resp_valid) resp_cnt0 <= resp_cnt0 + 1;
    if (p1_resp_valid) resp_cnt1 <= resp_cnt1 + 1;
    if (p0_resp_valid && p1_resp_valid) both_cnt <= both_cnt + 1;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {mem[a[11:0]], mem[a[11:0] + 12'd1], mem[a[11:0] + 12'd2], mem[a[11:0] + 12'd3]};
  endfunction

  task automatic set_req(input logic port, input logic we, input logic [1:0] size,
                         input logic sgn, input logic [31:0] addr, input logic [31:0] wdata);
    if (port == 1'b0) begin
      p0_req_valid = 1'b1; p0_req_we = we; p0_req_size = size;
      p0_req_signed = sgn; p0_req_addr = addr; p0_req_wdata = wdata;
    end else begin
      p1_req_valid = 1'b1; p1_req_we = we; p1_req_size = size;
      p1_req_signed = sgn; p1_req_addr = addr; p1_req_wdata = wdata;
    end
  endtask

  task automatic clr_req(input logic port);
    if (port == 1'b0) p0_req_valid = 1'b0;
    else p1_req_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Issue one request and follow it through to its single response pulse.
  task automatic do_txn(input logic port, input logic we, input logic [1:0] size,
                        input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err);
    int n;
    logic rdy;
    rdata = 32'hDEAD_0BAD;
    err   = 1'b1;
    set_req(port, we, size, sgn, addr, wdata);
    #1;
    n = 0;
    rdy = port ? p1_req_ready : p0_req_ready;
    while (!rdy && n < 12) begin
      @(posedge clk); #1;
      n++;
      rdy = port ? p1_req_ready : p0_req_ready;
    end
    if (!rdy) begin
      checks++; failures++;
      $display("FAIL txn_ready port=%0d addr=%h: ready not seen in %0d cycles, required 1", port, addr, n);
      clr_req(port);
      return;
    end
    @(posedge clk); #1;
    clr_req(port);
    @(posedge clk); #1;
    checks++;
    if ((port ? p1_resp_valid : p0_resp_valid) !== 1'b1) begin
      failures++;
      $display("FAIL resp_valid_lat port=%0d addr=%h: got 0, required 1", port, addr);
    end
    checks++;
    if ((port ? p0_resp_valid : p1_resp_valid) !== 1'b0) begin
      failures++;
      $display("FAIL other_port_valid port=%0d: got 1, required 0", port);
    end
    rdata = port ? p1_resp_rdata : p0_resp_rdata;
    err   = port ? p1_resp_err : p0_resp_err;
    @(posedge clk); #1;
    checks++;
    if ((port ? p1_resp_valid : p0_resp_valid) !== 1'b0) begin
      failures++;
      $display("FAIL resp_valid_pulse port=%0d: got 1, required 0", port);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({p0_resp_valid, p1_resp_valid, p0_resp_err, p1_resp_err, ram_we} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags got %b required 00000",
               {p0_resp_valid, p1_resp_valid, p0_resp_err, p1_resp_err, ram_we});
    end
    checks++;
    if (p0_resp_rdata !== 32'd0 || p1_resp_rdata !== 32'd0) begin
      failures++;
      $display("FAIL reset_rdata got %h/%h required 0/0", p0_resp_rdata, p1_resp_rdata);
    end
    checks++;
    if (p0_req_ready !== 1'b0 || p1_req_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready_idle got %b%b required 00", p0_req_ready, p1_req_ready);
    end
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er; int w0;
    w0 = we_count;
    do_txn(1'b0, 1'b1, T_WORD, 1'b0, 32'h10, 32'hDEADBEEF, rd, er);
    checks++;
    if (we_count != w0 + 1 || last_w_addr !== 32'h10 || last_w_data !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL word_store writes=%0d addr=%h data=%h required 1/00000010/deadbeef",
               we_count - w0, last_w_addr, last_w_data);
    end
    checks++;
    if (er !== 1'b0 || rd !== 32'd0) begin
      failures++;
      $display("FAIL word_store_ack err=%b rdata=%h required 0/00000000", er, rd);
    end
    do_txn(1'b0, 1'b0, T_WORD, 1'b0, 32'h10, 32'h0, rd, er);
    checks++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0 || we_count != w0 + 1) begin
      failures++;
      $display("FAIL word_load rdata=%h err=%b writes=%0d required deadbeef/0/1", rd, er, we_count - w0);
    end
  endtask

  task automatic test_subword();
    logic [31:0] rd; logic er;
    do_txn(1'b0, 1'b1, T_BYTE, 1'b0, 32'h10, 32'h123456A5, rd, er);
    checks++;
    if (mem_word(32'h10) !== 32'hA5ADBEEF) begin
      failures++;
      $display("FAIL byte_merge got %h required a5adbeef", mem_word(32'h10));
    end
    do_txn(1'b0, 1'b0, T_BYTE, 1'b1, 32'h10, 32'h0, rd, er);
    checks++;
    if (rd !== 32'hFFFFFFA5) begin
      failures++; $display("FAIL byte_load_signed got %h required ffffffa5", rd);
    end
    do_txn(1'b0, 1'b0, T_BYTE, 1'b0, 32'h10, 32'h0, rd, er);
    checks++;
    if (rd !== 32'h000000A5) begin
      failures++; $display("FAIL byte_load_unsigned got %h required 000000a5", rd);
    end
    do_txn(1'b0, 1'b0, T_HALF, 1'b1, 32'h11, 32'h0, rd, er);
    checks++;
    if (rd !== 32'hFFFFADBE) begin
      failures++; $display("FAIL half_load_signed got %h required ffffadbe", rd);
    end
    do_txn(1'b0, 1'b0, T_HALF, 1'b0, 32'h10, 32'h0, rd, er);
    checks++;
    if (rd !== 32'h0000A5AD) begin
      failures++; $display("FAIL half_load_unsigned got %h required 0000a5ad", rd);
    end
    do_txn(1'b0, 1'b1, T_WORD, 1'b0, 32'h20, 32'h11223344, rd, er);
    do_txn(1'b0, 1'b1, T_HALF, 1'b0, 32'h20, 32'hCAFEBEEF, rd, er);
    checks++;
    if (mem_word(32'h20) !== 32'hBEEF3344) begin
      failures++; $display("FAIL half_merge got %h required beef3344", mem_word(32'h20));
    end
  endtask

  task automatic test_back_to_back();
    int i0, i1, n, base0, base1, last_cyc;
    logic exp_port, got_port;
    do_reset();
    base0 = resp_cnt0; base1 = resp_cnt1;
    i0 = 0; i1 = 0; exp_port = 1'b0; last_cyc = 0;
    set_req(1'b0, 1'b1, T_WORD, 1'b0, 32'h100, 32'hA0000000);
    set_req(1'b1, 1'b1, T_WORD, 1'b0, 32'h200, 32'hB0000000);
    #1;
    for (int g = 0; g < 8; g++) begin
      n = 0;
      while (!p0_req_ready && !p1_req_ready && n < 10) begin
        @(posedge clk); #1; n++;
      end
      if (!p0_req_ready && !p1_req_ready) begin
        checks++; failures++;
        $display("FAIL b2b_ready grant=%0d: no ready in %0d cycles, required 1", g, n);
        break;
      end
      got_port = p1_req_ready;
      checks++;
      if (got_port !== exp_port) begin
        failures++; $display("FAIL b2b_grant idx=%0d got p%0d required p%0d", g, got_port, exp_port);
      end
      if (g > 0) begin
        checks++;
        if (cyc - last_cyc != 3) begin
          failures++; $display("FAIL b2b_spacing idx=%0d got %0d cycles required 3", g, cyc - last_cyc);
        end
      end
      last_cyc = cyc;
      @(posedge clk); #1;
      if (got_port == 1'b0) begin
        i0++;
        if (i0 < 4) set_req(1'b0, 1'b1, T_WORD, 1'b0, 32'h100 + 32'(4 * i0), 32'hA0000000 + 32'(i0));
        else clr_req(1'b0);
      end else begin
        i1++;
        if (i1 < 4) set_req(1'b1, 1'b1, T_WORD, 1'b0, 32'h200 + 32'(4 * i1), 32'hB0000000 + 32'(i1));
        else clr_req(1'b1);
      end
      if (i0 < 4 && i1 < 4) exp_port = ~got_port;
      else if (i0 < 4) exp_port = 1'b0;
      else exp_port = 1'b1;
    end
    clr_req(1'b0); clr_req(1'b1);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (resp_cnt0 - base0 != 4 || resp_cnt1 - base1 != 4) begin
      failures++;
      $display("FAIL b2b_resp_count got p0=%0d p1=%0d required 4/4", resp_cnt0 - base0, resp_cnt1 - base1);
    end
    checks++;
    if (both_cnt != 0) begin
      failures++; $display("FAIL b2b_dual_valid got %0d required 0", both_cnt);
    end
    checks++;
    if (mem_word(32'h10C) !== 32'hA0000003 || mem_word(32'h20C) !== 32'hB0000003) begin
      failures++;
      $display("FAIL b2b_data got %h/%h required a0000003/b0000003", mem_word(32'h10C), mem_word(32'h20C));
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int w0;
    do_txn(1'b0, 1'b1, T_WORD, 1'b0, 32'h40, 32'h55AA55AA, rd, er);
    w0 = we_count;
    do_txn(1'b0, 1'b1, T_WORD, 1'b0, 32'd4093, 32'h01010101, rd, er);
    checks++;
    if (er !== 1'b1 || rd !== 32'd0) begin
      failures++; $display("FAIL err_range_store err=%b rdata=%h required 1/00000000", er, rd);
    end
    do_txn(1'b0, 1'b1, T_RSVD, 1'b0, 32'h40, 32'h77777777, rd, er);
    checks++;
    if (er !== 1'b1) begin
      failures++; $display("FAIL err_size_store err=%b required 1", er);
    end
    do_txn(1'b0, 1'b0, T_WORD, 1'b0, 32'h40, 32'h0, rd, er);
    do_txn(1'b0, 1'b0, T_WORD, 1'b0, 32'd4093, 32'h0, rd, er);
    checks++;
    if (er !== 1'b1 || rd !== 32'd0) begin
      failures++; $display("FAIL err_range_load err=%b rdata=%h required 1/00000000", er, rd);
    end
    checks++;
    if (we_count != w0 || mem_word(32'h40) !== 32'h55AA55AA) begin
      failures++;
      $display("FAIL err_no_write writes=%0d word=%h required 0/55aa55aa", we_count - w0, mem_word(32'h40));
    end
    do_txn(1'b0, 1'b1, T_WORD, 1'b0, 32'd4092, 32'h01020304, rd, er);
    checks++;
    if (er !== 1'b0 || mem_word(32'd4092) !== 32'h01020304) begin
      failures++;
      $display("FAIL top_word_store err=%b word=%h required 0/01020304", er, mem_word(32'd4092));
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int w0, c0, n;
    do_txn(1'b0, 1'b1, T_WORD, 1'b0, 32'h80, 32'h0BADF00D, rd, er);
    w0 = we_count; c0 = resp_cnt0;
    set_req(1'b0, 1'b1, T_WORD, 1'b0, 32'h80, 32'h12345678);
    #1;
    n = 0;
    while (!p0_req_ready && n < 10) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    clr_req(1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (we_count != w0 || mem_word(32'h80) !== 32'h0BADF00D) begin
      failures++;
      $display("FAIL rst_mid_write writes=%0d word=%h required 0/0badf00d", we_count - w0, mem_word(32'h80));
    end
    checks++;
    if (resp_cnt0 != c0) begin
      failures++; $display("FAIL rst_mid_resp got %0d pulses required 0", resp_cnt0 - c0);
    end
    set_req(1'b0, 1'b0, T_WORD, 1'b0, 32'h80, 32'h0);
    #1;
    checks++;
    if (p0_req_ready !== 1'b1) begin
      failures++; $display("FAIL rst_mid_idle ready got %b required 1", p0_req_ready);
    end
    clr_req(1'b0);
    do_txn(1'b0, 1'b1, T_WORD, 1'b0, 32'h80, 32'h12345678, rd, er);
    checks++;
    if (mem_word(32'h80) !== 32'h12345678 || er !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_reissue word=%h err=%b required 12345678/0", mem_word(32'h80), er);
    end
  endtask

  task automatic test_p1_alone();
    logic [31:0] rd; logic er; int c0;
    c0 = resp_cnt0;
    for (int k = 0; k < 3; k++) begin
      do_txn(1'b1, 1'b1, T_WORD, 1'b0, 32'h300 + 32'(4 * k), 32'hC0DE0000 + 32'(k), rd, er);
    end
    do_txn(1'b1, 1'b0, T_HALF, 1'b0, 32'h308, 32'h0, rd, er);
    checks++;
    if (rd !== 32'h0000C0DE || er !== 1'b0) begin
      failures++; $display("FAIL p1_alone_load rdata=%h err=%b required 0000c0de/0", rd, er);
    end
    checks++;
    if (resp_cnt0 != c0) begin
      failures++; $display("FAIL p1_alone_p0_quiet got %0d pulses required 0", resp_cnt0 - c0);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_subword();
    test_back_to_back();
    test_errors();
    test_reset_mid();
    test_p1_alone();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
